uart_cmd_decoder: RTL and testbench
===================================

// Module: uart_cmd_decoder
// PURPOSE
//   Frames UART receive bytes into register-write commands for the 32-entry
//   byte demultiplexer that follows it. Two-byte frame: header byte (tag +
//   5-bit register index), then data byte. Drives the demux select/data with a
//   one-cycle write strobe. Aborts a frame whose data byte does not arrive in time.
// PARAMETERS
//   HDR_TAG      3'b101  required value of header bits [7:5]
//   TIMEOUT_CYC  50000   max clk cycles from header accept to data byte
//   CNT_W        16      width of the timeout counter (must hold TIMEOUT_CYC-1)
// PORTS
//   clk        in   1   system clock, all state on rising edge
//   reset      in   1   asynchronous, active-high reset
//   rx_data    in   8   byte from UART receiver, valid when rx_valid=1
//   rx_valid   in   1   one-cycle pulse per received byte
//   sel        out  6   demux select; [4:0]=register index, [5] always 0
//   wdata      out  8   demux data byte
//   wr_en      out  1   one-cycle pulse: sel/wdata hold a new committed write
//   busy       out  1   1 while a header is held awaiting its data byte
//   err_hdr    out  1   one-cycle pulse: byte in IDLE with bad tag
//   err_tmo    out  1   one-cycle pulse: frame aborted by timeout
//   frame_cnt  out  8   committed frames, wraps 255->0
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, sel=0, wdata=0, wr_en=0, busy=0,
//     err_hdr=0, err_tmo=0, frame_cnt=0, timer=0, held index=0.
//   All outputs registered. States: IDLE, WAIT_DATA, COMMIT.
//   IDLE: rx_valid & rx_data[7:5]==HDR_TAG -> hold index=rx_data[4:0],
//     timer=0, -> WAIT_DATA. rx_valid & tag mismatch -> err_hdr=1 next cycle,
//     stay IDLE. No rx_valid -> stay.
//   WAIT_DATA: busy=1. rx_valid -> any byte value accepted as data (no tag
//     check), hold it, -> COMMIT. Else timer+1; when timer==TIMEOUT_CYC-1 with
//     no rx_valid -> err_tmo=1 next cycle, discard header, -> IDLE.
//     rx_valid on the expiry cycle: data wins, no err_tmo.
//   COMMIT (exactly one cycle): wr_en=1; sel={1'b0,index}, wdata=data
//     updated in the same cycle; frame_cnt+1 (mod 256); -> IDLE.
//     rx_valid during COMMIT is evaluated exactly as in IDLE (header accept
//     or err_hdr), so back-to-back bytes are never dropped.
//   Latency: data byte rx_valid at cycle N -> wr_en=1 at cycle N+1.
//   sel/wdata change only at COMMIT; held stable between writes, including
//     across err_hdr/err_tmo and aborted frames.
//   Reset mid-frame: held header discarded, no wr_en, no error pulse.
//   err_hdr, err_tmo, wr_en never assert in the same cycle as each other.
// TESTING
//   1 Reset, then header 8'hA3, data 8'h5C -> 1 cycle after data: wr_en=1,
//     sel=6'd3, wdata=8'h5C, frame_cnt=1; wr_en=0 next cycle.
//   2 Header 8'h43 (tag 3'b010) in IDLE -> err_hdr pulse, no busy,
//     sel/wdata unchanged.
//   3 TIMEOUT_CYC=8: header 8'hBF, no further bytes -> err_tmo pulse 8
//     cycles after header accept, busy drops, no wr_en; next header 8'hA1
//     + data 8'h11 -> sel=1, wdata=8'h11.
//   4 TIMEOUT_CYC=8: data byte arrives on expiry cycle -> wr_en, no err_tmo.
//   5 Back-to-back: A0,01,A1,02 on consecutive cycles -> two wr_en pulses,
//     (sel=0,wdata=01) then (sel=1,wdata=02); header during COMMIT accepted.
//   6 Assert reset while busy after header 8'hA7 -> all outputs zero, no
//     wr_en; 256 committed frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Frames two-byte UART commands (tagged header + data) into one-cycle register
// writes for the downstream 32-entry demux, with a data-byte timeout.
module uart_cmd_decoder #(
  parameter logic [2:0] HDR_TAG     = 3'b101,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [5:0] sel,
  output logic [7:0] wdata,
  output logic       wr_en,
  output logic       busy,
  output logic       err_hdr,
  output logic       err_tmo,
  output logic [7:0] frame_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    COMMIT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  // Handshake: rx_valid is a single-cycle qualifier for rx_data; there is no
  // back-pressure, so every byte must be consumed in the cycle it is offered.
  state_t           state, state_n;
  logic [4:0]       index, index_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [5:0]       sel_n;
  logic [7:0]       wdata_n;
  logic [7:0]       frame_cnt_n;
  logic             wr_en_n, busy_n, err_hdr_n, err_tmo_n;

  always_comb begin
    state_n     = state;
    index_n     = index;
    timer_n     = timer;
    sel_n       = sel;
    wdata_n     = wdata;
    frame_cnt_n = frame_cnt;
    wr_en_n     = 1'b0;
    err_hdr_n   = 1'b0;
    err_tmo_n   = 1'b0;
    case (state)
      // COMMIT only lasts one cycle, so it treats incoming bytes like IDLE
      // to keep back-to-back frames lossless.
      IDLE, COMMIT: begin
        state_n = IDLE;
        if (rx_valid) begin
          if (rx_data[7:5] == HDR_TAG) begin
            index_n = rx_data[4:0];
            timer_n = '0;
            state_n = WAIT_DATA;
          end else begin
            err_hdr_n = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        if (rx_valid) begin
          sel_n       = {1'b0, index};
          wdata_n     = rx_data;
          wr_en_n     = 1'b1;
          frame_cnt_n = frame_cnt + 8'd1;
          state_n     = COMMIT;
        end else if (timer == TMO_LAST) begin
          err_tmo_n = 1'b1;
          index_n   = '0;
          timer_n   = '0;
          state_n   = IDLE;
        end else begin
          timer_n = timer + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == WAIT_DATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      timer     <= '0;
      sel       <= '0;
      wdata     <= '0;
      frame_cnt <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      err_hdr   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      state     <= state_n;
      index     <= index_n;
      timer     <= timer_n;
      sel       <= sel_n;
      wdata     <= wdata_n;
      frame_cnt <= frame_cnt_n;
      wr_en     <= wr_en_n;
      busy      <= busy_n;
      err_hdr   <= err_hdr_n;
      err_tmo   <= err_tmo_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a vector table for the single-cycle
// behaviour, hand sequences for timeout, reset and counter wrap.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [5:0] sel;
  logic [7:0] wdata;
  logic       wr_en, busy, err_hdr, err_tmo;
  logic [7:0] frame_cnt;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_bad = 0;
  logic [13:0] exp_q[$];

  uart_cmd_decoder #(.HDR_TAG(3'b101), .TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .sel(sel), .wdata(wdata), .wr_en(wr_en), .busy(busy), .err_hdr(err_hdr),
    .err_tmo(err_tmo), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       wr;
    logic [5:0] s;
    logic [7:0] wd;
    logic       b;
    logic       eh;
    logic       et;
    logic [7:0] c;
    string      name;
  } vec_t;

  vec_t vecs[17];

  // Apply one byte (or idle) for one clock; outputs are read 1 time unit later.
  task automatic apply(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic wr, input logic [5:0] s,
                       input logic [7:0] wd, input logic b, input logic eh,
                       input logic et, input logic [7:0] c);
    logic [25:0] act, exp;
    act = {wr_en, sel, wdata, busy, err_hdr, err_tmo, frame_cnt};
    exp = {wr, s, wd, b, eh, et, c};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got wr=%b sel=%0d wdata=%h busy=%b eh=%b et=%b cnt=%0d, want wr=%b sel=%0d wdata=%h busy=%b eh=%b et=%b cnt=%0d",
               name, wr_en, sel, wdata, busy, err_hdr, err_tmo, frame_cnt,
               wr, s, wd, b, eh, et, c);
    end
  endtask

  // Write scoreboard: every wr_en pulse must match the oldest expected write.
  always @(posedge clk) begin
    #2;
    if (wr_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got sel=%0d wdata=%h, want no write", sel, wdata);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        if ({sel, wdata} !== e) begin
          n_bad++;
          $display("FAIL write_payload: got sel=%0d wdata=%h, want sel=%0d wdata=%h",
                   sel, wdata, e[13:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 6'd0,  8'h00, 1'b0, 1'b0, 1'b0, 8'd0, "idle0"};
    vecs[1]  = '{1'b1, 8'hA3, 1'b0, 6'd0,  8'h00, 1'b1, 1'b0, 1'b0, 8'd0, "hdr_a3"};
    vecs[2]  = '{1'b1, 8'h5C, 1'b1, 6'd3,  8'h5C, 1'b0, 1'b0, 1'b0, 8'd1, "data_5c"};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 6'd3,  8'h5C, 1'b0, 1'b0, 1'b0, 8'd1, "post_commit"};
    vecs[4]  = '{1'b1, 8'h43, 1'b0, 6'd3,  8'h5C, 1'b0, 1'b1, 1'b0, 8'd1, "bad_tag"};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 6'd3,  8'h5C, 1'b0, 1'b0, 1'b0, 8'd1, "after_bad"};
    vecs[6]  = '{1'b1, 8'hA0, 1'b0, 6'd3,  8'h5C, 1'b1, 1'b0, 1'b0, 8'd1, "b2b_hdr0"};
    vecs[7]  = '{1'b1, 8'h01, 1'b1, 6'd0,  8'h01, 1'b0, 1'b0, 1'b0, 8'd2, "b2b_data0"};
    vecs[8]  = '{1'b1, 8'hA1, 1'b0, 6'd0,  8'h01, 1'b1, 1'b0, 1'b0, 8'd2, "b2b_hdr_in_commit"};
    vecs[9]  = '{1'b1, 8'h02, 1'b1, 6'd1,  8'h02, 1'b0, 1'b0, 1'b0, 8'd3, "b2b_data1"};
    vecs[10] = '{1'b1, 8'hBF, 1'b0, 6'd1,  8'h02, 1'b1, 1'b0, 1'b0, 8'd3, "hdr_bf_in_commit"};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 6'd1,  8'h02, 1'b1, 1'b0, 1'b0, 8'd3, "wait_gap"};
    vecs[12] = '{1'b1, 8'hE5, 1'b1, 6'd31, 8'hE5, 1'b0, 1'b0, 1'b0, 8'd4, "data_any_tag"};
    vecs[13] = '{1'b1, 8'h00, 1'b0, 6'd31, 8'hE5, 1'b0, 1'b1, 1'b0, 8'd4, "bad_in_commit"};
    vecs[14] = '{1'b1, 8'hA2, 1'b0, 6'd31, 8'hE5, 1'b1, 1'b0, 1'b0, 8'd4, "hdr_a2"};
    vecs[15] = '{1'b1, 8'hA3, 1'b1, 6'd2,  8'hA3, 1'b0, 1'b0, 1'b0, 8'd5, "data_like_hdr"};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 6'd2,  8'hA3, 1'b0, 1'b0, 1'b0, 8'd5, "idle_end"};

    // Clock/reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) exp_q.push_back({vecs[i].s, vecs[i].wd});
      apply(vecs[i].v, vecs[i].d);
      check(vecs[i].name, vecs[i].wr, vecs[i].s, vecs[i].wd, vecs[i].b,
            vecs[i].eh, vecs[i].et, vecs[i].c);
    end

    // Timeout: no data byte after header, abort after 8 waiting cycles.
    apply(1'b1, 8'hBF);
    check("tmo_hdr", 1'b0, 6'd2, 8'hA3, 1'b1, 1'b0, 1'b0, 8'd5);
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 8'h00);
      check("tmo_waiting", 1'b0, 6'd2, 8'hA3, 1'b1, 1'b0, 1'b0, 8'd5);
    end
    apply(1'b0, 8'h00);
    check("tmo_pulse", 1'b0, 6'd2, 8'hA3, 1'b0, 1'b0, 1'b1, 8'd5);
    apply(1'b0, 8'h00);
    check("tmo_after", 1'b0, 6'd2, 8'hA3, 1'b0, 1'b0, 1'b0, 8'd5);
    apply(1'b1, 8'hA1);
    check("tmo_next_hdr", 1'b0, 6'd2, 8'hA3, 1'b1, 1'b0, 1'b0, 8'd5);
    exp_q.push_back({6'd1, 8'h11});
    apply(1'b1, 8'h11);
    check("tmo_next_data", 1'b1, 6'd1, 8'h11, 1'b0, 1'b0, 1'b0, 8'd6);

    // Data byte on the expiry cycle wins over the timeout.
    apply(1'b1, 8'hA4);
    check("exp_hdr", 1'b0, 6'd1, 8'h11, 1'b1, 1'b0, 1'b0, 8'd6);
    for (int i = 0; i < 7; i++) apply(1'b0, 8'h00);
    check("exp_last_wait", 1'b0, 6'd1, 8'h11, 1'b1, 1'b0, 1'b0, 8'd6);
    exp_q.push_back({6'd4, 8'h77});
    apply(1'b1, 8'h77);
    check("exp_data_wins", 1'b1, 6'd4, 8'h77, 1'b0, 1'b0, 1'b0, 8'd7);
    apply(1'b0, 8'h00);
    check("exp_no_late_tmo", 1'b0, 6'd4, 8'h77, 1'b0, 1'b0, 1'b0, 8'd7);

    // Asynchronous reset while a header is held.
    apply(1'b1, 8'hA7);
    check("rst_busy", 1'b0, 6'd4, 8'h77, 1'b1, 1'b0, 1'b0, 8'd7);
    #2 reset = 1'b1;
    #1;
    check("rst_async", 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    apply(1'b0, 8'h00);
    check("rst_release", 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    apply(1'b0, 8'h00);
    check("rst_no_write", 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);

    // 256 committed frames wrap frame_cnt to zero.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] cnt_exp;
      logic [4:0] idx;
      idx = 5'(i);
      cnt_exp = 8'(i + 1);
      apply(1'b1, {3'b101, idx});
      exp_q.push_back({1'b0, idx, 8'(255 - i)});
      apply(1'b1, 8'(255 - i));
      check("wrap_frame", 1'b1, {1'b0, idx}, 8'(255 - i), 1'b0, 1'b0, 1'b0, cnt_exp);
    end
    apply(1'b0, 8'h00);
    check("wrap_zero", 1'b0, 6'd31, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);

    repeat (2) @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL write_drain: got %0d writes outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
